// File: rtl/octave_mode_ctrl.sv
// Octave / waveform-mode register pair stepped by keypad strobes.
// Define MUTE_EN to add the click-suppression sequencer (mute around each change).
module octave_mode_ctrl #(
  parameter int OCT_MAX     = 3,
  parameter int OCT_INIT    = 2,
  parameter int MUTE_CYCLES = 256,
  parameter int OCT_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             octave_pulse,
  input  logic             mode_pulse,
  output logic [OCT_W-1:0] octave,
  output logic [1:0]       mode,
  output logic             mute,
  output logic             change
);

  if (OCT_INIT > OCT_MAX) begin : g_bad_init
    $error("OCT_INIT must not exceed OCT_MAX");
  end
  if (MUTE_CYCLES < 1) begin : g_bad_mute
    $error("MUTE_CYCLES must be at least 1");
  end

  function automatic logic [OCT_W-1:0] step_oct(input logic [OCT_W-1:0] o);
    return (o == OCT_W'(OCT_MAX)) ? '0 : o + OCT_W'(1);
  endfunction

  function automatic logic [1:0] step_mode(input logic [1:0] m);
    return m + 2'd1;
  endfunction

  logic [OCT_W-1:0] octave_nxt;
  logic [1:0]       mode_nxt;
  logic             change_nxt;

`ifdef MUTE_EN
  localparam int CNT_W = $clog2(MUTE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRE, APPLY, POST} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_oct, pend_mode, pend_oct_nxt, pend_mode_nxt;
  logic             lat_oct, lat_mode, lat_oct_nxt, lat_mode_nxt;
  logic             mute_r, mute_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_oct  <= 1'b0;
      pend_mode <= 1'b0;
      lat_oct   <= 1'b0;
      lat_mode  <= 1'b0;
      mute_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend_oct  <= pend_oct_nxt;
      pend_mode <= pend_mode_nxt;
      lat_oct   <= lat_oct_nxt;
      lat_mode  <= lat_mode_nxt;
      mute_r    <= mute_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pend_oct_nxt  = pend_oct;
    pend_mode_nxt = pend_mode;
    lat_oct_nxt   = lat_oct;
    lat_mode_nxt  = lat_mode;
    octave_nxt    = octave;
    mode_nxt      = mode;
    change_nxt    = 1'b0;
    // While busy, presses collapse into one pending step per type.
    if (state != IDLE) begin
      pend_oct_nxt  = pend_oct | octave_pulse;
      pend_mode_nxt = pend_mode | mode_pulse;
    end
    case (state)
      IDLE: begin
        if (octave_pulse | pend_oct | mode_pulse | pend_mode) begin
          lat_oct_nxt   = octave_pulse | pend_oct;
          lat_mode_nxt  = mode_pulse | pend_mode;
          pend_oct_nxt  = 1'b0;
          pend_mode_nxt = 1'b0;
          cnt_nxt       = CNT_LOAD;
          state_nxt     = PRE;
        end
      end
      PRE: begin
        if (cnt == '0) state_nxt = APPLY;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      APPLY: begin
        if (lat_oct)  octave_nxt = step_oct(octave);
        if (lat_mode) mode_nxt   = step_mode(mode);
        change_nxt = 1'b1;
        cnt_nxt    = CNT_LOAD;
        state_nxt  = POST;
      end
      POST: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    mute_nxt = (state_nxt != IDLE);
  end

  assign mute = mute_r;
`else
  always_comb begin
    octave_nxt = octave_pulse ? step_oct(octave) : octave;
    mode_nxt   = mode_pulse ? step_mode(mode) : mode;
    change_nxt = octave_pulse | mode_pulse;
  end

  assign mute = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      octave <= OCT_W'(OCT_INIT);
      mode   <= 2'd0;
      change <= 1'b0;
    end else begin
      octave <= octave_nxt;
      mode   <= mode_nxt;
      change <= change_nxt;
    end
  end

endmodule

// File: tb/tb_octave_mode_ctrl.sv
// Scoreboard bench for octave_mode_ctrl; follows MUTE_EN like the design.
module tb_octave_mode_ctrl;
  localparam int OCT_MAX  = 3;
  localparam int OCT_INIT = 2;
  localparam int M        = 4;
  localparam int OCT_W    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             octave_pulse;
  logic             mode_pulse;
  logic [OCT_W-1:0] octave;
  logic [1:0]       mode;
  logic             mute;
  logic             change;

  octave_mode_ctrl #(
    .OCT_MAX(OCT_MAX), .OCT_INIT(OCT_INIT), .MUTE_CYCLES(M), .OCT_W(OCT_W)
  ) dut (
    .clk(clk), .rst(rst), .octave_pulse(octave_pulse), .mode_pulse(mode_pulse),
    .octave(octave), .mode(mode), .mute(mute), .change(change)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OCT_W-1:0] oct;
    logic [1:0]       mode;
    logic             mute;
    logic             chg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: timing expressed as absolute cycle numbers.
  int   cyc = 0;
  int   idle_at = 0;
  int   apply_at = -1;
  int   mute_end = -1;
  bit   pend_o, pend_m, lat_o, lat_m;
  int   m_oct = OCT_INIT;
  int   m_mode = 0;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_step(input bit po, input bit pm, input bit r);
    exp_t e;
    bit   chg = 1'b0;
    if (r) begin
      m_oct = OCT_INIT; m_mode = 0;
      idle_at = 0; apply_at = -1; mute_end = -1;
      pend_o = 0; pend_m = 0; lat_o = 0; lat_m = 0;
    end else begin
`ifdef MUTE_EN
      if (cyc >= idle_at) begin
        if (po || pm || pend_o || pend_m) begin
          lat_o = po | pend_o; lat_m = pm | pend_m;
          pend_o = 0; pend_m = 0;
          apply_at = cyc + M + 2;
          mute_end = cyc + 2*M + 1;
          idle_at  = cyc + 2*M + 2;
        end
      end else begin
        pend_o |= po; pend_m |= pm;
      end
      if (cyc + 1 == apply_at) begin
        if (lat_o) m_oct = (m_oct + 1) % (OCT_MAX + 1);
        if (lat_m) m_mode = (m_mode + 1) % 4;
        chg = 1'b1;
      end
`else
      if (po) m_oct = (m_oct + 1) % (OCT_MAX + 1);
      if (pm) m_mode = (m_mode + 1) % 4;
      chg = po | pm;
`endif
    end
    e.oct  = OCT_W'(m_oct);
    e.mode = 2'(m_mode);
`ifdef MUTE_EN
    e.mute = (cyc + 1 <= mute_end);
`else
    e.mute = 1'b0;
`endif
    e.chg  = chg;
    sb_q.push_back(e);
  endtask

  task automatic tick(input bit po, input bit pm, input bit r);
    exp_t e;
    octave_pulse = po; mode_pulse = pm; rst = r;
    model_step(po, pm, r);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_val("octave", int'(octave), int'(e.oct));
      check_val("mode",   int'(mode),   int'(e.mode));
      check_val("mute",   int'(mute),   int'(e.mute));
      check_val("change", int'(change), int'(e.chg));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; octave_pulse = 1'b0; mode_pulse = 1'b0;
    @(posedge clk); #1;
    // Reset with both strobes held high.
    tick(1, 1, 1);
    tick(1, 1, 1);
    idle(3);
`ifdef MUTE_EN
    tick(1, 0, 0); idle(2*M + 3);
    tick(1, 0, 0); idle(2*M + 3);
    for (int k = 0; k < 4; k++) begin
      tick(0, 1, 0); idle(2*M + 3);
    end
    // Both strobes together, then three octave presses during POST.
    tick(1, 1, 0);
    idle(M + 2);
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    idle(3*M + 6);
    // Reset two cycles into PRE, with a press pending.
    tick(1, 0, 0); tick(0, 1, 0);
    tick(0, 0, 1);
    idle(2*M + 4);
    // Back-to-back presses: pending starts the next sequence right away.
    tick(0, 1, 0); tick(1, 0, 0);
    idle(4*M + 8);
`else
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    idle(2);
    for (int k = 0; k < 5; k++) tick(0, 1, 0);
    tick(1, 1, 0); tick(1, 1, 0);
    idle(1);
    tick(1, 1, 1);
    idle(2);
`endif
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 120) == 0);
    idle(2*M + 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
